ray_sphere_sequencer: RTL and testbench

RAY_SPHERE_SEQUENCER -- requirements
Module: ray_sphere_sequencer

---
 rtl/ray_sphere_sequencer.sv | 156 +++++++++++++++
 tb/tb_ray_sphere_sequencer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/ray_sphere_sequencer.sv
// ray_sphere_sequencer: serial ray/sphere intersection (setup, discriminant, sqrt, two divisions, projection)
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   ax/ay/az, bx/by/bz, r       ray origin, ray direction, sphere radius (captured on acceptance)
//   in_valid/in_ready           request handshake, in_ready only in IDLE
//   out_valid/out_ready         result handshake, results held in DONE until retired
//   hit, err                    ray meets sphere / degenerate direction
//   px1..pz2                    intersection points for t1 and t2 (zero on miss or err)
//   busy                        high whenever not IDLE
module ray_sphere_sequencer #(
  parameter int WIDTH = 32,
  parameter int FRAC = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [WIDTH-1:0] ax,
  input  logic signed [WIDTH-1:0] ay,
  input  logic signed [WIDTH-1:0] az,
  input  logic signed [WIDTH-1:0] bx,
  input  logic signed [WIDTH-1:0] by,
  input  logic signed [WIDTH-1:0] bz,
  input  logic signed [WIDTH-1:0] r,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    hit,
  output logic                    err,
  output logic signed [WIDTH-1:0] px1,
  output logic signed [WIDTH-1:0] py1,
  output logic signed [WIDTH-1:0] pz1,
  output logic signed [WIDTH-1:0] px2,
  output logic signed [WIDTH-1:0] py2,
  output logic signed [WIDTH-1:0] pz2,
  output logic                    busy
);
  localparam int CW = $clog2(WIDTH + FRAC + 1);
  localparam logic [CW-1:0] SQ_LAST = CW'(WIDTH / 2 - 1);
  localparam logic [CW-1:0] DV_LAST = CW'(WIDTH + FRAC - 1);
  localparam logic [2:0] IDLE = 3'd0, SETUP = 3'd1, DISC = 3'd2, SQRT = 3'd3,
                         DIV1 = 3'd4, DIV2 = 3'd5, PROJ = 3'd6, DONE = 3'd7;
  logic [2:0] st;
  logic signed [WIDTH-1:0] ax_r, ay_r, az_r, bx_r, by_r, bz_r, r_r;
  logic signed [WIDTH-1:0] qa, qb, qc, t1, t2;
  logic signed [WIDTH-1:0] a_n, b_n, c_n, d_n;
  logic [WIDTH-1:0] dq, sr, root, sr_sh, trial, sr_nx, root_nx;
  logic [WIDTH-1:0] den, q, rem, rem_nx, q_nx, t_nx, num, mag;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH+FRAC-1:0] dvd;
  logic [CW-1:0] cnt;
  logic sge, dge, neg, last, ld;
  function automatic logic signed [WIDTH-1:0] proj(input logic signed [WIDTH-1:0] a, b, t);
    logic signed [WIDTH-1:0] m;
    m = b * t;
    return a + (m >>> FRAC);
  endfunction
  assign in_ready = st == IDLE;
  assign busy = st != IDLE;
  assign out_valid = st == DONE;
  assign a_n = bx_r * bx_r + by_r * by_r + bz_r * bz_r;
  assign b_n = (ax_r * bx_r + ay_r * by_r + az_r * bz_r) <<< 1;
  assign c_n = ax_r * ax_r + ay_r * ay_r + az_r * az_r - r_r * r_r;
  assign d_n = qb * qb - ((qa * qc) <<< 2);
  // dq shifts D out two bits at a time, MSB pair first, into the sqrt remainder
  always_comb begin
    sr_sh = (sr << 2) | (dq >> (WIDTH - 2));
    trial = (root << 2) | WIDTH'(1);
    sge = sr_sh >= trial;
    sr_nx = sge ? sr_sh - trial : sr_sh;
    root_nx = (root << 1) | WIDTH'(sge);
  end
  // divider works on |n|*2^FRAC and restores the sign on the quotient
  always_comb begin
    rem_sh = {rem, dvd[WIDTH+FRAC-1]};
    dge = rem_sh >= {1'b0, den};
    rem_nx = dge ? WIDTH'(rem_sh - {1'b0, den}) : rem_sh[WIDTH-1:0];
    q_nx = (q << 1) | WIDTH'(dge);
    t_nx = neg ? -q_nx : q_nx;
    // at the end of SQRT the root register is not yet updated, so use root_nx
    num = st == SQRT ? root_nx - qb : -qb - root;
    mag = num[WIDTH-1] ? -num : num;
    last = cnt == (st == SQRT ? SQ_LAST : DV_LAST);
    ld = last && (st == SQRT || st == DIV1);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st <= IDLE;
      {ax_r, ay_r, az_r, bx_r, by_r, bz_r, r_r} <= '0;
      {qa, qb, qc, t1, t2} <= '0;
      {dq, sr, root, den, q, rem, dvd} <= '0;
      cnt <= '0;
      neg <= 1'b0;
      hit <= 1'b0;
      err <= 1'b0;
      {px1, py1, pz1, px2, py2, pz2} <= '0;
    end else begin
      case (st)
        IDLE: if (in_valid) begin
          {ax_r, ay_r, az_r, bx_r, by_r, bz_r, r_r} <= {ax, ay, az, bx, by, bz, r};
          hit <= 1'b0;
          err <= 1'b0;
          {px1, py1, pz1, px2, py2, pz2} <= '0;
          st <= SETUP;
        end
        SETUP: begin
          qa <= a_n;
          qb <= b_n;
          qc <= c_n;
          st <= DISC;
        end
        DISC: begin
          dq <= d_n;
          sr <= '0;
          root <= '0;
          cnt <= '0;
          err <= qa == '0;
          st <= (qa == '0 || d_n[WIDTH-1]) ? DONE : SQRT;
        end
        SQRT: begin
          dq <= dq << 2;
          sr <= sr_nx;
          root <= root_nx;
          cnt <= last ? '0 : cnt + CW'(1);
          st <= last ? DIV1 : SQRT;
        end
        DIV1, DIV2: begin
          dvd <= dvd << 1;
          rem <= rem_nx;
          q <= q_nx;
          cnt <= last ? '0 : cnt + CW'(1);
          if (last && st == DIV1) t1 <= t_nx;
          if (last && st == DIV2) t2 <= t_nx;
          st <= !last ? st : st == DIV1 ? DIV2 : PROJ;
        end
        PROJ: begin
          px1 <= proj(ax_r, bx_r, t1);
          py1 <= proj(ay_r, by_r, t1);
          pz1 <= proj(az_r, bz_r, t1);
          px2 <= proj(ax_r, bx_r, t2);
          py2 <= proj(ay_r, by_r, t2);
          pz2 <= proj(az_r, bz_r, t2);
          hit <= 1'b1;
          st <= DONE;
        end
        DONE: st <= out_ready ? IDLE : DONE;
      endcase
      if (ld) begin
        rem <= '0;
        q <= '0;
        den <= qa << 1;
        neg <= num[WIDTH-1];
        dvd <= {mag, {FRAC{1'b0}}};
      end
    end
  end
endmodule

// File: tb/tb_ray_sphere_sequencer.sv
// tb_ray_sphere_sequencer: directed and random requests checked against an arithmetic reference model
module tb_ray_sphere_sequencer;
  localparam int W = 32;
  localparam int F = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic signed [W-1:0] ax, ay, az, bx, by, bz, r;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic in_ready, out_valid, hit, err, busy;
  logic signed [W-1:0] px1, py1, pz1, px2, py2, pz2;
  int checks = 0;
  int errors = 0;
  logic e_hit, e_err;
  int e_lat;
  longint e_p[6];
  always #5 clk = ~clk;
  ray_sphere_sequencer #(.WIDTH(W), .FRAC(F)) dut (
    .clk(clk), .rst_n(rst_n),
    .ax(ax), .ay(ay), .az(az), .bx(bx), .by(by), .bz(bz), .r(r),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .hit(hit), .err(err),
    .px1(px1), .py1(py1), .pz1(pz1), .px2(px2), .py2(py2), .pz2(pz2),
    .busy(busy)
  );
  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask
  // quadratic solved directly with 64-bit arithmetic; inputs kept small so nothing wraps
  task automatic model(input int a0, a1, a2, b0, b1, b2, rr);
    longint av[3], bv[3], aa, bb, cc, dd, s, n, t;
    av = '{longint'(a0), longint'(a1), longint'(a2)};
    bv = '{longint'(b0), longint'(b1), longint'(b2)};
    aa = bv[0] * bv[0] + bv[1] * bv[1] + bv[2] * bv[2];
    bb = 2 * (av[0] * bv[0] + av[1] * bv[1] + av[2] * bv[2]);
    cc = av[0] * av[0] + av[1] * av[1] + av[2] * av[2] - longint'(rr) * longint'(rr);
    dd = bb * bb - 4 * aa * cc;
    e_err = aa == 0;
    e_hit = !e_err && dd >= 0;
    e_lat = e_hit ? 4 + W / 2 + 2 * (W + F) : 3;
    foreach (e_p[i]) e_p[i] = 0;
    if (e_hit) begin
      s = 0;
      while ((s + 1) * (s + 1) <= dd) s++;
      for (int k = 0; k < 2; k++) begin
        n = k == 0 ? -bb + s : -bb - s;
        t = n < 0 ? -(((-n) << F) / (2 * aa)) : (n << F) / (2 * aa);
        for (int j = 0; j < 3; j++) e_p[3 * k + j] = av[j] + ((bv[j] * t) >>> F);
      end
    end
  endtask
  task automatic check_out(input string tag);
    chk({tag, " hit"}, hit, e_hit);
    chk({tag, " err"}, err, e_err);
    chk({tag, " px1"}, px1, e_p[0]);
    chk({tag, " py1"}, py1, e_p[1]);
    chk({tag, " pz1"}, pz1, e_p[2]);
    chk({tag, " px2"}, px2, e_p[3]);
    chk({tag, " py2"}, py2, e_p[4]);
    chk({tag, " pz2"}, pz2, e_p[5]);
  endtask
  task automatic scramble();
    ax = $urandom; ay = $urandom; az = $urandom;
    bx = $urandom; by = $urandom; bz = $urandom; r = $urandom;
  endtask
  task automatic request(input string tag, input int a0, a1, a2, b0, b1, b2, rr, input int hold);
    int lat;
    model(a0, a1, a2, b0, b1, b2, rr);
    chk({tag, " in_ready idle"}, in_ready, 1);
    ax = a0; ay = a1; az = a2; bx = b0; by = b1; bz = b2; r = rr;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble();
    lat = 1;
    while (!out_valid && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " out_valid"}, out_valid, 1);
    chk({tag, " latency"}, lat, e_lat);
    check_out(tag);
    for (int c = 0; c < hold; c++) begin
      in_valid = 1'b1;
      scramble();
      @(posedge clk); #1;
      chk({tag, " held out_valid"}, out_valid, 1);
      chk({tag, " held in_ready"}, in_ready, 0);
      check_out({tag, " held"});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, " retired out_valid"}, out_valid, 0);
    chk({tag, " retired in_ready"}, in_ready, 1);
    chk({tag, " retired busy"}, busy, 0);
  endtask
  initial begin
    int seen;
    ax = 0; ay = 0; az = -5; bx = 0; by = 0; bz = 1; r = 3;
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready", in_ready, 1);
    chk("reset out_valid", out_valid, 0);
    chk("reset busy", busy, 0);
    chk("reset hit", hit, 0);
    chk("reset err", err, 0);
    chk("reset p", {px1, py1, pz1, px2, py2, pz2} == '0, 1);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("no accept in reset", busy, 0);
    request("hit", 0, 0, -5, 0, 0, 1, 3, 0);
    request("tangent", 0, 3, -5, 0, 0, 1, 3, 0);
    request("miss", 0, 0, -5, 1, 0, 0, 3, 0);
    request("degenerate", 7, -2, 4, 0, 0, 0, 5, 0);
    request("backpressure", 0, 0, -5, 0, 0, 1, 3, 10);
    request("backpressure miss", 0, 0, -5, 1, 0, 0, 3, 4);
    ax = 0; ay = 0; az = -5; bx = 0; by = 0; bz = 1; r = 3;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    chk("mid div busy", busy, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("mid reset in_ready", in_ready, 1);
    chk("mid reset busy", busy, 0);
    chk("mid reset out_valid", out_valid, 0);
    chk("mid reset hit", hit, 0);
    seen = 0;
    repeat (150) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("abandoned result", seen, 0);
    request("post reset hit", 0, 0, -5, 0, 0, 1, 3, 0);
    for (int i = 0; i < 24; i++) begin
      int a0, a1, a2, b0, b1, b2, rr;
      a0 = int'($urandom_range(40)) - 20;
      a1 = int'($urandom_range(40)) - 20;
      a2 = int'($urandom_range(40)) - 20;
      b0 = int'($urandom_range(12)) - 6;
      b1 = int'($urandom_range(12)) - 6;
      b2 = int'($urandom_range(12)) - 6;
      if ($urandom_range(7) == 0) begin
        b0 = 0; b1 = 0; b2 = 0;
      end
      rr = int'($urandom_range(30));
      request($sformatf("rnd%0d", i), a0, a1, a2, b0, b1, b2, rr, int'($urandom_range(2)));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
